// File: rtl/ac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ac_pkg
// Brief    : Shared widths, depth and FSM state encoding for the
//            Aho-Corasick goto-table lookup.
// Revision : 1.0 - initial release
// ============================================================================
package ac_pkg;

    // Default geometry of the goto table
    localparam int c_DEF_STATE_W = 8;
    localparam int c_DEF_CHAR_W  = 4;
    localparam int c_DEF_DEPTH   = 32;

    // Lookup controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } ac_state_e;

endpackage : ac_pkg
`default_nettype wire

// File: rtl/ac_goto_table.sv
`default_nettype none
// ============================================================================
// Module   : ac_goto_table
// Brief    : Goto-table storage. One synchronous write port, one
//            asynchronous read port by index, valid bits cleared on reset.
// Revision : 1.0 - initial release
// ============================================================================
module ac_goto_table
    import ac_pkg::*;
#(
    parameter int STATE_W = c_DEF_STATE_W,
    parameter int CHAR_W  = c_DEF_CHAR_W,
    parameter int DEPTH   = c_DEF_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               WR_EN,
    input  logic [ADDR_W-1:0]  WR_ADDR,
    input  logic               WR_VALID,
    input  logic [STATE_W-1:0] WR_STATE,
    input  logic [CHAR_W-1:0]  WR_CHAR,
    input  logic [STATE_W-1:0] WR_NEXT,
    input  logic [ADDR_W-1:0]  RD_ADDR,
    output logic               RD_VALID,
    output logic [STATE_W-1:0] RD_STATE,
    output logic [CHAR_W-1:0]  RD_CHAR,
    output logic [STATE_W-1:0] RD_NEXT
);

    logic [DEPTH-1:0]   r_valid;
    logic [STATE_W-1:0] r_state_mem [DEPTH];
    logic [CHAR_W-1:0]  r_char_mem  [DEPTH];
    logic [STATE_W-1:0] r_next_mem  [DEPTH];

    // Valid bits: reset clears all of them and takes priority over a write
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid <= '0;
        end else if (WR_EN) begin
            r_valid[WR_ADDR] <= WR_VALID;
        end
    end

    // Entry payload: never reset, only meaningful while its valid bit is set
    always_ff @(posedge CLK) begin
        if (WR_EN) begin
            r_state_mem[WR_ADDR] <= WR_STATE;
            r_char_mem[WR_ADDR]  <= WR_CHAR;
            r_next_mem[WR_ADDR]  <= WR_NEXT;
        end
    end

    // Asynchronous read shows contents as of the start of the current cycle
    assign RD_VALID = r_valid[RD_ADDR];
    assign RD_STATE = r_state_mem[RD_ADDR];
    assign RD_CHAR  = r_char_mem[RD_ADDR];
    assign RD_NEXT  = r_next_mem[RD_ADDR];

endmodule : ac_goto_table
`default_nettype wire

// File: rtl/ac_goto_lookup.sv
`default_nettype none
// ============================================================================
// Module   : ac_goto_lookup
// Brief    : Sequential goto-function lookup. Scans the goto table one entry
//            per cycle for (state, char); lowest matching index wins. A miss
//            from the root state optionally resolves to a root self-loop.
// Revision : 1.0 - initial release
// ============================================================================
module ac_goto_lookup
    import ac_pkg::*;
#(
    parameter int STATE_W        = c_DEF_STATE_W,
    parameter int CHAR_W         = c_DEF_CHAR_W,
    parameter int DEPTH          = c_DEF_DEPTH,
    parameter int ROOT_SELF_LOOP = 1,
    localparam int ADDR_W        = $clog2(DEPTH)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               WR_EN,
    input  logic [ADDR_W-1:0]  WR_ADDR,
    input  logic               WR_VALID,
    input  logic [STATE_W-1:0] WR_STATE,
    input  logic [CHAR_W-1:0]  WR_CHAR,
    input  logic [STATE_W-1:0] WR_NEXT,
    input  logic               REQ_VALID,
    output logic               REQ_READY,
    input  logic [STATE_W-1:0] REQ_STATE,
    input  logic [CHAR_W-1:0]  REQ_CHAR,
    output logic               RSP_VALID,
    input  logic               RSP_READY,
    output logic               RSP_HIT,
    output logic [STATE_W-1:0] RSP_NEXT,
    output logic [ADDR_W-1:0]  RSP_ADDR
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

    ac_state_e          r_state;
    logic [ADDR_W-1:0]  r_ptr;
    logic [STATE_W-1:0] r_req_state;
    logic [CHAR_W-1:0]  r_req_char;
    logic               r_rsp_hit;
    logic [STATE_W-1:0] r_rsp_next;
    logic [ADDR_W-1:0]  r_rsp_addr;

    logic               w_rd_valid;
    logic [STATE_W-1:0] w_rd_state;
    logic [CHAR_W-1:0]  w_rd_char;
    logic [STATE_W-1:0] w_rd_next;
    logic               w_match;
    logic               w_root_miss;

    ac_goto_table #(
        .STATE_W (STATE_W),
        .CHAR_W  (CHAR_W),
        .DEPTH   (DEPTH)
    ) u_table (
        .CLK      (CLK),
        .RST      (RST),
        .WR_EN    (WR_EN),
        .WR_ADDR  (WR_ADDR),
        .WR_VALID (WR_VALID),
        .WR_STATE (WR_STATE),
        .WR_CHAR  (WR_CHAR),
        .WR_NEXT  (WR_NEXT),
        .RD_ADDR  (r_ptr),
        .RD_VALID (w_rd_valid),
        .RD_STATE (w_rd_state),
        .RD_CHAR  (w_rd_char),
        .RD_NEXT  (w_rd_next)
    );

    // Entry under the scan pointer matches the latched request
    assign w_match = w_rd_valid && (w_rd_state == r_req_state) && (w_rd_char == r_req_char);

    // Root state has an implicit transition to itself on every unmatched char
    assign w_root_miss = (ROOT_SELF_LOOP != 0) && (r_req_state == '0);

    // Lookup controller with registered response fields
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_req_state <= '0;
            r_req_char  <= '0;
            r_rsp_hit   <= 1'b0;
            r_rsp_next  <= '0;
            r_rsp_addr  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (REQ_VALID) begin
                        r_req_state <= REQ_STATE;
                        r_req_char  <= REQ_CHAR;
                        r_ptr       <= '0;
                        r_state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_match) begin
                        r_rsp_hit  <= 1'b1;
                        r_rsp_next <= w_rd_next;
                        r_rsp_addr <= r_ptr;
                        r_state    <= RESP;
                    end else if (r_ptr == c_LAST_ADDR) begin
                        // Exhausted the table; pointer stays put, no wrap
                        r_rsp_hit  <= w_root_miss;
                        r_rsp_next <= '0;
                        r_rsp_addr <= '0;
                        r_state    <= RESP;
                    end else begin
                        r_ptr <= r_ptr + ADDR_W'(1);
                    end
                end
                RESP: begin
                    if (RSP_READY) begin
                        r_rsp_hit  <= 1'b0;
                        r_rsp_next <= '0;
                        r_rsp_addr <= '0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign REQ_READY = (r_state == IDLE);
    assign RSP_VALID = (r_state == RESP);
    assign RSP_HIT   = r_rsp_hit;
    assign RSP_NEXT  = r_rsp_next;
    assign RSP_ADDR  = r_rsp_addr;

endmodule : ac_goto_lookup
`default_nettype wire

// File: doc/ac_goto_lookup.md
AC_GOTO_LOOKUP -- requirements
Module: ac_goto_lookup

Interface
REQ-001 SHALL have parameter STATE_W, default 8, state-number width.
REQ-002 SHALL have parameter CHAR_W, default 4, input-character width.
REQ-003 SHALL have parameter DEPTH, default 32, number of goto-table entries (power of two, >=2); ADDR_W = clog2(DEPTH).
REQ-004 SHALL have parameter ROOT_SELF_LOOP, default 1, which enables the root miss-to-self rule.
REQ-005 SHALL have ports, one clock and a synchronous active-high reset:
 CLK  in  1  sole clock, rising edge
 RST  in  1  synchronous active-high reset
 WR_EN  in  1  table write strobe
 WR_ADDR  in  ADDR_W  entry index
 WR_VALID  in  1  entry valid bit to store
 WR_STATE  in  STATE_W  entry current state
 WR_CHAR  in  CHAR_W  entry character
 WR_NEXT  in  STATE_W  entry next state
 REQ_VALID  in  1  lookup request
 REQ_READY  out  1  lookup accepted when both high
 REQ_STATE  in  STATE_W  current state
 REQ_CHAR  in  CHAR_W  input character
 RSP_VALID  out  1  result available
 RSP_READY  in  1  result consumed when both high
 RSP_HIT  out  1  transition found
 RSP_NEXT  out  STATE_W  next state
 RSP_ADDR  out  ADDR_W  matching entry index (0 on miss)

Function
REQ-006 SHALL store DEPTH entries {valid, state, char, next}; a write with WR_EN high updates entry WR_ADDR at the clock edge, in any FSM state.
REQ-007 SHALL implement FSM IDLE -> SCAN -> RESP -> IDLE.
REQ-008 REQ_READY SHALL be high only in IDLE; acceptance latches REQ_STATE/REQ_CHAR, clears the scan pointer, and enters SCAN.
REQ-009 In SCAN, SHALL compare one entry per cycle, pointer p = 0,1,...; match = valid && state==latched state && char==latched char.
REQ-010 On a match at p, SHALL enter RESP with RSP_HIT=1, RSP_NEXT=entry next, RSP_ADDR=p; the lowest matching index wins.
REQ-011 If no match when p==DEPTH-1, SHALL enter RESP with a miss; the pointer does not wrap.
REQ-012 Miss result: RSP_HIT=0, RSP_NEXT=0, RSP_ADDR=0, except ROOT_SELF_LOOP=1 with latched state==0 gives RSP_HIT=1, RSP_NEXT=0.
REQ-013 Latency: match at index k gives RSP_VALID high k+1 cycles after the acceptance edge; a miss gives it DEPTH cycles after.
REQ-014 RSP_VALID SHALL be high only in RESP; RSP_* SHALL be held stable until RSP_READY is high, then return to IDLE. There is no back-to-back overlap: REQ_READY rises the cycle after the response handshake.
REQ-015 A compare SHALL see table contents as of the start of its cycle; a write to entry p in the same cycle affects only later compares.
REQ-016 RSP_HIT, RSP_NEXT and RSP_ADDR SHALL be 0 whenever RSP_VALID is low.

Reset
REQ-017 RST high at a clock edge SHALL force IDLE, REQ_READY=1 in the following cycle, RSP_VALID=0, all RSP_* outputs =0, and the scan pointer =0.
REQ-018 RST SHALL clear every entry valid bit; state/char/next contents need not be cleared.
REQ-019 RST mid-SCAN or mid-RESP SHALL abort the lookup with no response issued.
REQ-020 RST and WR_EN in the same cycle: reset wins and the entry is left invalid.

Structure
REQ-021 Shared package ac_pkg SHALL hold default widths/depth and the FSM state enum (IDLE, SCAN, RESP).
REQ-022 Table storage (write port, asynchronous read by index, valid-bit clear) SHALL be sub-module ac_goto_table; FSM and compare logic live in ac_goto_lookup.

Verification
REQ-023 Load entry 0 {1,0x00,0x1,0x01}, request (0x00,0x1) -> RSP_VALID 1 cycle after accept, HIT=1, NEXT=0x01, ADDR=0.
REQ-024 Load entry 31 {1,0x05,0xA,0x07} only, request (0x05,0xA) -> RSP_VALID after 32 cycles, NEXT=0x07, ADDR=31.
REQ-025 Empty table, request (0x03,0x2) -> miss after 32 cycles, HIT=0, NEXT=0; request (0x00,0x2) with ROOT_SELF_LOOP=1 -> HIT=1, NEXT=0.
REQ-026 Duplicate matches at entries 4 and 9 -> ADDR=4; hold RSP_READY low 5 cycles -> outputs stable and REQ_READY low throughout.
REQ-027 Assert RST during SCAN at p=10 -> no RSP_VALID, REQ_READY high next cycle, prior entries invalid (re-request misses).
REQ-028 Write entry 6 while p==6 in the same cycle -> this lookup misses; a repeat lookup hits at ADDR=6.
